// File: rtl/imm_scan_ctrl.sv
// imm_scan_ctrl: frame-scan sequencer for the image masking datapath.
// Walks one frame in raster order: read the source pixel, present it to imm for
// MASK_LAT cycles, then write the masked result to the VGA buffer.
// Optional feature macro: IMM_SKIP_OUTSIDE_EN. When it is defined, pixels
// outside the mask window are skipped and cost one cycle each.
// Handshake: a request (rd_req/wr_req) is held high with address and data
// stable until the matching ack is seen high on a rising clk edge. The ack may
// arrive in the same cycle the request rises. The request drops the cycle after
// the ack. abort overrides any ack seen in the same cycle.
module imm_scan_ctrl #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
`ifdef IMM_SKIP_OUTSIDE_EN
    parameter int MASK_W   = 64,
    parameter int MASK_H   = 64,
`endif
    parameter int MASK_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [8:0]  i_offset,
    input  logic [7:0]  j_offset,
    output logic        busy,
    output logic        done,
    output logic        rd_req,
    output logic [16:0] rd_addr,
    input  logic        rd_ack,
    input  logic [11:0] rd_data,
    output logic [11:0] dp_pixel,
    output logic [8:0]  dp_i,
    output logic [7:0]  dp_j,
    output logic [8:0]  dp_i_offset,
    output logic [7:0]  dp_j_offset,
    input  logic [11:0] dp_result,
    output logic        wr_req,
    output logic [16:0] wr_addr,
    output logic [11:0] wr_data,
    input  logic        wr_ack,
    output logic [16:0] pix_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_MASK = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int              LAT_W    = (MASK_LAT > 1) ? $clog2(MASK_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MASK_LAT - 1);
    localparam logic [8:0]      I_LAST   = 9'(IMG_W - 1);
    localparam logic [7:0]      J_LAST   = 8'(IMG_H - 1);

    state_t            state_q, state_d;
    logic [8:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [16:0]       addr_q, addr_d;
    logic [8:0]        i_off_q, i_off_d;
    logic [7:0]        j_off_q, j_off_d;
    logic [11:0]       pixel_q, pixel_d;
    logic [11:0]       wdata_q, wdata_d;
    logic [16:0]       pix_cnt_q, pix_cnt_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              advance;
    logic              last_pix;

    assign last_pix = (i_q == I_LAST) && (j_q == J_LAST);

`ifdef IMM_SKIP_OUTSIDE_EN
    // Strict window test, widened by one bit so offset+size never wraps.
    logic in_win;
    assign in_win = ({1'b0, i_off_q} < {1'b0, i_q})
                 && ({1'b0, i_q} < ({1'b0, i_off_q} + 10'(MASK_W)))
                 && ({1'b0, j_off_q} < {1'b0, j_q})
                 && ({1'b0, j_q} < ({1'b0, j_off_q} + 9'(MASK_H)));
`endif

    // Next-state and datapath-register update for the scan sequencer.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        addr_d    = addr_q;
        i_off_d   = i_off_q;
        j_off_d   = j_off_q;
        pixel_d   = pixel_q;
        wdata_d   = wdata_q;
        pix_cnt_d = pix_cnt_q;
        lat_d     = lat_q;
        advance   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    i_off_d   = i_offset;
                    j_off_d   = j_offset;
                    i_d       = 9'd0;
                    j_d       = 8'd0;
                    addr_d    = 17'd0;
                    pix_cnt_d = 17'd0;
                    lat_d     = '0;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                if (abort) begin
                    state_d = S_IDLE;
`ifdef IMM_SKIP_OUTSIDE_EN
                end else if (!in_win) begin
                    advance = 1'b1;
`endif
                end else if (rd_ack) begin
                    pixel_d = rd_data;
                    lat_d   = '0;
                    state_d = S_MASK;
                end
            end
            S_MASK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (lat_q == LAT_LAST) begin
                    wdata_d = dp_result;
                    state_d = S_WR;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_WR: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (wr_ack) begin
                    pix_cnt_d = pix_cnt_q + 17'd1;
                    advance   = 1'b1;
                end
            end
            S_DONE: begin
                i_d     = 9'd0;
                j_d     = 8'd0;
                addr_d  = 17'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Raster advance; the address tracks j*IMG_W+i incrementally.
        if (advance) begin
            if (last_pix) begin
                state_d = S_DONE;
            end else begin
                state_d = S_RD;
                addr_d  = addr_q + 17'd1;
                if (i_q == I_LAST) begin
                    i_d = 9'd0;
                    j_d = j_q + 8'd1;
                end else begin
                    i_d = i_q + 9'd1;
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            i_q       <= 9'd0;
            j_q       <= 8'd0;
            addr_q    <= 17'd0;
            i_off_q   <= 9'd0;
            j_off_q   <= 8'd0;
            pixel_q   <= 12'd0;
            wdata_q   <= 12'd0;
            pix_cnt_q <= 17'd0;
            lat_q     <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            addr_q    <= addr_d;
            i_off_q   <= i_off_d;
            j_off_q   <= j_off_d;
            pixel_q   <= pixel_d;
            wdata_q   <= wdata_d;
            pix_cnt_q <= pix_cnt_d;
            lat_q     <= lat_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
`ifdef IMM_SKIP_OUTSIDE_EN
    assign rd_req      = (state_q == S_RD) && in_win;
`else
    assign rd_req      = (state_q == S_RD);
`endif
    assign wr_req      = (state_q == S_WR);
    assign rd_addr     = addr_q;
    assign wr_addr     = addr_q;
    assign dp_pixel    = pixel_q;
    assign dp_i        = i_q;
    assign dp_j        = j_q;
    assign dp_i_offset = i_off_q;
    assign dp_j_offset = j_off_q;
    assign wr_data     = wdata_q;
    assign pix_count   = pix_cnt_q;

endmodule
